led_arb: RTL and testbench
==========================

# led_arb

Round-robin scheduler that shares one board status LED among `NUM_REQ` requesters. Each requester shows a blink code: N blinks followed by a dark gap. The block has a prescaled tick generator, a blink/gap FSM and a rotating-priority arbiter. It sits between the PL test logic (self-test, link-up and error flags) and the single user LED pin, and replaces free-running per-signal blinkers.

## Interface
Parameters:
- `CLK_FREQ`, 50000000: input clock frequency in Hz.
- `TICK_HZ`, 10: blink half-period rate. `TICK_DIV = CLK_FREQ / TICK_HZ` cycles per tick.
- `NUM_REQ`, 4: number of requesters, 2..8.
- `CNT_W`, 4: width of each blink count.
- `GAP_TICKS`, 10: dark ticks after each code, ≥1.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: asynchronous, active-high reset.
- `req`  in  `NUM_REQ`: level request, one bit per requester.
- `blink_cnt`  in  `NUM_REQ*CNT_W`: requester i's count is at `[i*CNT_W +: CNT_W]`.
- `grant`  out  `NUM_REQ`: one-hot owner of the LED, or all zero.
- `done`  out  `NUM_REQ`: one-cycle pulse when the owner's code completes.
- `busy`  out  1: high while any grant is held.
- `led`  out  1: LED drive, 1 = lit.

## Operation
- Reset value of every output is 0. The FSM goes to IDLE, the round-robin pointer goes to 0 and the prescaler is cleared.
- Prescaler: counts 0..TICK_DIV-1 and wraps. `tick` is high on count TICK_DIV-1. The prescaler clears on every state entry.
- FSM states:
  - IDLE: if `req` is non-zero, pick the first set bit searching upward from the pointer, wrapping modulo `NUM_REQ`. Latch that requester's `blink_cnt` into `remain`. Go to ON if `remain` ≠ 0, else go to GAP.
  - ON: `led`=1. On tick, go to OFF.
  - OFF: `led`=0. On tick, decrement `remain`. If the new value is 0, go to GAP, else go to ON.
  - GAP: `led`=0. Count ticks. On tick number GAP_TICKS, pulse `done[owner]`, set pointer = (owner+1) mod `NUM_REQ`, and go to IDLE.
- `grant` and `busy` are high in ON, OFF and GAP.
- `req` and `blink_cnt` are sampled only in IDLE. Later changes are ignored unless the abort feature is compiled in.
- `remain` is `CNT_W` bits wide, so the maximum code is 2^CNT_W−1 blinks.
- Simultaneous requests are served in pointer order, one full code each. No requester waits more than `NUM_REQ`−1 codes.

## Timing
- `req` seen in IDLE at cycle T: `grant`, `busy` and `led` (if count ≠ 0) are registered high at T+1.
- One blink is TICK_DIV cycles lit followed by TICK_DIV cycles dark.
- Grant duration = (2·count + GAP_TICKS)·TICK_DIV cycles.
- `done` is high during the last grant cycle. `grant` drops the following cycle.
- There is at least one IDLE cycle between consecutive grants.
- Asynchronous `rst` mid-code forces all outputs to 0 at once. The interrupted code is lost and no `done` is pulsed.

## Configuration
- `LED_ARB_ABORT_EN` defined:
  - In ON, OFF or GAP, if `req[owner]` is sampled low, the next cycle returns to IDLE with `led`=0 and `grant`=0.
  - No `done` is pulsed. The pointer advances to owner+1.
- `LED_ARB_ABORT_EN` undefined: a started code always runs to completion regardless of `req`.

## Test plan
Parameters for all tests: CLK_FREQ=100, TICK_HZ=10 (TICK_DIV=10), NUM_REQ=4, GAP_TICKS=2.
- Single request, `req`=0001, count0=3:
  - `grant`=0001 for 80 cycles.
  - `led` shows 3×(10 high, 10 low), then 20 dark cycles.
  - `done[0]` pulses on grant cycle 80.
- All four requesting, `req`=1111, all counts=1: grants go 0001, 0010, 0100, 1000, each 40 cycles, each separated by one IDLE cycle, with a `done` pulse in order.
- Fairness: `req[0]` held high, `req[2]` raised during requester 0's code. The next grant is 0100, then 0001.
- Zero count, count1=0: `grant`=0010 for 20 cycles, `led` stays 0, `done[1]` pulses.
- Reset mid-code: `rst` asserted in the 2nd ON phase drives `led`, `grant` and `busy` to 0 immediately. After release with `req`=1111, the first grant is 0001.
- With `LED_ARB_ABORT_EN` defined, `req[0]` dropped in OFF: `grant` goes to 0 next cycle with no `done`, and the pointer moves to 1. Without the macro, the code completes normally.

Source files
------------

// File: rtl/led_arb.sv
// led_arb: round-robin owner of a single status LED. The owner blinks its
// code (N lit/dark pairs of one tick each), then the LED stays dark for
// GAP_TICKS ticks before the next requester is served.
// Optional build macro: LED_ARB_ABORT_EN. When defined, a started code is
// abandoned as soon as the owner drops its request.
`timescale 1ns/1ps

module led_arb #(
  parameter int CLK_FREQ  = 50000000,
  parameter int TICK_HZ   = 10,
  parameter int NUM_REQ   = 4,
  parameter int CNT_W     = 4,
  parameter int GAP_TICKS = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] blink_cnt,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic                     led
);

  localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
  localparam int PS_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GP_W     = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam int IDX_W    = $clog2(NUM_REQ);

  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(TICK_DIV - 1);
  localparam logic [GP_W-1:0]  GP_LAST  = GP_W'(GAP_TICKS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_owner;
  logic [CNT_W-1:0]   r_remain;
  logic [PS_W-1:0]    r_presc;
  logic [GP_W-1:0]    r_gap;

  state_t             w_next;
  logic               w_tick;
  logic               w_pick_valid;
  logic [IDX_W-1:0]   w_pick_idx;
  logic [NUM_REQ-1:0] w_done;
  logic [CNT_W-1:0]   w_cnt [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
    assign w_cnt[gi] = blink_cnt[gi*CNT_W +: CNT_W];
  end

  assign w_tick = (r_presc == PS_LAST);

  // Rotating-priority pick: first set request at or above the pointer, wrapping.
  always_comb begin
    int j;
    // NOTE: every variable gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    j            = 0;
    w_pick_valid = 1'b0;
    w_pick_idx   = r_ptr;
    // Walk offsets from farthest to nearest so the nearest hit wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(r_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req[IDX_W'(j)]) begin
        w_pick_valid = 1'b1;
        w_pick_idx   = IDX_W'(j);
      end
    end
  end

  // Next-state logic and the end-of-code done pulse.
  always_comb begin
    w_next = r_state;
    w_done = '0;
    case (r_state)
      S_IDLE: if (w_pick_valid) w_next = (w_cnt[w_pick_idx] != '0) ? S_ON : S_GAP;
      S_ON:   if (w_tick) w_next = S_OFF;
      S_OFF:  if (w_tick) w_next = (r_remain == CNT_W'(1)) ? S_GAP : S_ON;
      S_GAP:  if (w_tick && r_gap == GP_LAST) begin
                w_next          = S_IDLE;
                w_done[r_owner] = 1'b1;
              end
      default: w_next = S_IDLE;
    endcase
`ifdef LED_ARB_ABORT_EN
    // Owner withdrew: abandon the code silently.
    if (r_state != S_IDLE && !req[r_owner]) begin
      w_next = S_IDLE;
      w_done = '0;
    end
`endif
  end

  // State, prescaler, gap counter, owner/count latch and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_owner  <= '0;
      r_remain <= '0;
      r_presc  <= '0;
      r_gap    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here sees the
      // pre-edge values; blocking ones would make results depend on order.
      r_state <= w_next;

      // Restart the tick phase on every state entry so each phase is whole.
      if (w_next != r_state || w_tick) r_presc <= '0;
      else                             r_presc <= r_presc + PS_W'(1);

      if (r_state != S_GAP) r_gap <= '0;
      else if (w_tick)      r_gap <= r_gap + GP_W'(1);

      if (r_state == S_IDLE && w_pick_valid) begin
        r_owner  <= w_pick_idx;
        r_remain <= w_cnt[w_pick_idx];
      end else if (r_state == S_OFF && w_tick) begin
        r_remain <= r_remain - CNT_W'(1);
      end

      // Leaving a grant (completed or aborted) hands priority to the next one.
      if (r_state != S_IDLE && w_next == S_IDLE)
        r_ptr <= (r_owner == IDX_LAST) ? '0 : r_owner + IDX_W'(1);
    end
  end

  // Outputs decode straight from registered state, so reset clears them at once.
  always_comb begin
    grant          = '0;
    grant[r_owner] = (r_state != S_IDLE);
    busy           = (r_state != S_IDLE);
    led            = (r_state == S_ON);
    done           = w_done;
  end

endmodule

// File: tb/tb_led_arb.sv
// tb_led_arb: table of arbitration scenarios plus hand-written sequences for
// fairness, reset mid-code and owner withdrawal. Expected grant episodes go
// into a queue when stimulus is applied; a monitor rebuilds each observed
// episode and compares it against the head of the queue.
`timescale 1ns/1ps

module tb_led_arb;

  localparam int TD = 10;  // TICK_DIV = 100 / 10
  localparam int GT = 2;   // GAP_TICKS

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [15:0] blink_cnt = '0;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic        led;

  led_arb #(
    .CLK_FREQ(100), .TICK_HZ(10), .NUM_REQ(4), .CNT_W(4), .GAP_TICKS(GT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .blink_cnt(blink_cnt),
    .grant(grant), .done(done), .busy(busy), .led(led)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] grant;
    int         cnt;
    int         len;
    bit         dn;
    int         gap;   // idle cycles before this grant, -1 = don't care
  } exp_t;

  typedef struct packed {
    logic [3:0]  req;
    logic [15:0] cnt;
    logic [2:0]  n;
    logic [15:0] order;  // expected grants, first in the low nibble
  } vec_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // ---------------- monitor ----------------
  bit         in_ep = 1'b0;
  logic [3:0] ep_grant;
  int         ep_len, ep_err, ep_done_at, ep_gap;
  int         idle_cnt = 0;
  int         idle_err = 0;
  bit         ep_led[$];

  task automatic finish_ep();
    exp_t e;
    int   bad;
    if (sb.size() == 0) begin
      check("unexpected_grant", int'(ep_grant), 0);
      return;
    end
    e = sb.pop_front();
    check("grant", int'(ep_grant), int'(e.grant));
    check("grant_len", ep_len, e.len);
    bad = 0;
    foreach (ep_led[c])
      if (ep_led[c] != ((c < 2*TD*e.cnt) && ((c % (2*TD)) < TD))) bad++;
    check("led_pattern_errs", bad, 0);
    check("done_cycle", ep_done_at, e.dn ? e.len - 1 : -1);
    check("protocol_errs", ep_err, 0);
    if (e.gap >= 0) check("idle_gap", ep_gap, e.gap);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (in_ep) finish_ep();
      in_ep    = 1'b0;
      idle_cnt = 0;
    end else if (grant != '0) begin
      if (!in_ep) begin
        in_ep      = 1'b1;
        ep_grant   = grant;
        ep_len     = 0;
        ep_err     = 0;
        ep_done_at = -1;
        ep_gap     = idle_cnt;
        ep_led.delete();
      end
      if (grant != ep_grant || !busy) ep_err++;
      if (done != '0) begin
        if (done != ep_grant || ep_done_at >= 0) ep_err++;
        ep_done_at = ep_len;
      end
      ep_led.push_back(led);
      ep_len++;
    end else begin
      if (busy || led || done != '0) idle_err++;
      if (in_ep) begin
        finish_ep();
        in_ep    = 1'b0;
        idle_cnt = 0;
      end
      idle_cnt++;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic drive(input logic [3:0] r, input logic [15:0] c);
    @(posedge clk);
    #1;
    req       = r;
    blink_cnt = c;
  endtask

  task automatic push_exp(input logic [3:0] g, input int c, input int len,
                          input bit dn, input int gap);
    exp_t e;
    e.grant = g; e.cnt = c; e.len = len; e.dn = dn; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (t < 1000) begin
      @(negedge clk);
      if (done != '0) break;
      t++;
    end
    if (t >= 1000) timeout(name);
  endtask

  task automatic wait_grant(input logic want_busy, input string name);
    int t;
    t = 0;
    while (t < 1000) begin
      @(negedge clk);
      if ((grant != '0) == want_busy) break;
      t++;
    end
    if (t >= 1000) timeout(name);
  endtask

  task automatic run_vec(input vec_t v);
    for (int k = 0; k < int'(v.n); k++) begin
      logic [3:0] g;
      int         c;
      g = v.order[k*4 +: 4];
      c = 0;
      for (int i = 0; i < 4; i++) if (g[i]) c = int'(v.cnt[i*4 +: 4]);
      push_exp(g, c, (2*c + GT)*TD, 1'b1, (k == 0) ? -1 : 1);
    end
    drive(v.req, v.cnt);
    for (int k = 0; k < int'(v.n); k++) wait_done("vec_done");
    drive(4'b0000, v.cnt);
  endtask

  // ---------------- test ----------------
  vec_t vecs[7];

  initial begin
    // Pointer carries over between rows; the expected order accounts for it.
    vecs[0] = '{4'b1111, 16'h1111, 3'd4, {4'b1000, 4'b0100, 4'b0010, 4'b0001}};
    vecs[1] = '{4'b0001, 16'hFFF3, 3'd1, 16'h0001};                       // count 3
    vecs[2] = '{4'b0010, 16'hFF0F, 3'd1, 16'h0002};                       // zero count
    vecs[3] = '{4'b0101, 16'hF1F2, 3'd2, {8'h00, 4'b0001, 4'b0100}};
    vecs[4] = '{4'b1000, 16'hF000, 3'd1, 16'h0008};                       // max code
    vecs[5] = '{4'b0110, 16'hF05F, 3'd2, {8'h00, 4'b0100, 4'b0010}};
    vecs[6] = '{4'b1001, 16'h4FF2, 3'd2, {8'h00, 4'b0001, 4'b1000}};      // wraps

    #2;
    check("rst_grant", int'(grant), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_led", int'(led), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vecs[v]) run_vec(vecs[v]);

    // Fairness: requester 2 arrives mid-code and is served before 0 again.
    push_exp(4'b0001, 1, (2 + GT)*TD, 1'b1, -1);
    push_exp(4'b0100, 1, (2 + GT)*TD, 1'b1, 1);
    push_exp(4'b0001, 1, (2 + GT)*TD, 1'b1, 1);
    drive(4'b0001, 16'h1111);
    wait_grant(1'b1, "fair_start");
    repeat (5) @(negedge clk);
    req = 4'b0101;
    for (int k = 0; k < 3; k++) wait_done("fair_done");
    drive(4'b0000, 16'h1111);

    // Reset during the second lit phase of a 3-blink code.
    push_exp(4'b0001, 3, 25, 1'b0, -1);
    drive(4'b0001, 16'hFFF3);
    wait_grant(1'b1, "rst_start");
    repeat (24) @(negedge clk);
    check("led_before_rst", int'(led), 1);
    #1;
    rst = 1'b1;
    req = 4'b0000;
    #1;
    check("midrst_grant", int'(grant), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_led", int'(led), 0);
    check("midrst_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push_exp(4'b0001, 1, (2 + GT)*TD, 1'b1, -1);
    drive(4'b1111, 16'h1111);
    wait_done("post_rst_done");
    drive(4'b0000, 16'h1111);

    // Owner drops its request in the dark half of its first blink.
`ifdef LED_ARB_ABORT_EN
    push_exp(4'b0001, 2, 14, 1'b0, -1);
`else
    push_exp(4'b0001, 2, (4 + GT)*TD, 1'b1, -1);
`endif
    drive(4'b0001, 16'h1112);
    wait_grant(1'b1, "drop_start");
    repeat (12) @(negedge clk);
    drive(4'b0000, 16'h1112);
    wait_grant(1'b0, "drop_end");
    // Pointer now sits at 1 in both builds.
    push_exp(4'b0010, 1, (2 + GT)*TD, 1'b1, -1);
    push_exp(4'b0001, 1, (2 + GT)*TD, 1'b1, 1);
    drive(4'b0011, 16'h1111);
    wait_done("ptr_done_a");
    wait_done("ptr_done_b");
    drive(4'b0000, 16'h1111);

    // Drain the scoreboard.
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (sb.size() == 0 && !in_ep) break;
    end
    check("scoreboard_left", sb.size(), 0);
    check("idle_protocol_errs", idle_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
